// File: rtl/regfile_port_arb.sv
// Register-file port arbiter: shares the core's writeback and rs2 read ports
// with a debug master through a 2-entry in-order request FIFO.
module regfile_port_arb #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_core_rs1_addr,
  input  logic [4:0]  i_core_rs2_addr,
  input  logic        i_core_wren,
  input  logic [4:0]  i_core_rd_addr,
  input  logic [31:0] i_core_rd_data,
  output logic        o_core_stall,
  input  logic        i_dbg_valid,
  input  logic        i_dbg_we,
  input  logic [4:0]  i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_ready,
  output logic        o_dbg_rvalid,
  output logic [31:0] o_dbg_rdata,
  output logic [4:0]  o_rf_rs1_addr,
  output logic [4:0]  o_rf_rs2_addr,
  input  logic [31:0] i_rf_rs2_data,
  output logic        o_rf_rd_wren,
  output logic [4:0]  o_rf_rd_addr,
  output logic [31:0] o_rf_rd_data
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DBG_RD       = 2'd1,
    DBG_WR_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] FORCE_CNT = 4'(STARVE_LIMIT - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  starve_cnt_r;
  logic [3:0]  starve_cnt_nxt_s;

  logic        fifo_we_r   [2];
  logic [4:0]  fifo_addr_r [2];
  logic [31:0] fifo_data_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic [1:0]  count_nxt_s;
  logic        rd_ptr_nxt_s;

  logic        dbg_rvalid_r;
  logic [31:0] dbg_rdata_r;

  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        empty_s;
  logic        blocked_s;
  logic        dbg_wr_s;
  logic        nxt_head_rd_s;
  logic        head_we_s;
  logic [4:0]  head_addr_s;
  logic [31:0] head_data_s;

  assign full_s       = (count_r == 2'd2);
  assign empty_s      = (count_r == 2'd0);
  assign o_dbg_ready  = !full_s && !i_reset;
  assign push_s       = i_dbg_valid && o_dbg_ready;
  assign head_we_s    = fifo_we_r[rd_ptr_r];
  assign head_addr_s  = fifo_addr_r[rd_ptr_r];
  assign head_data_s  = fifo_data_r[rd_ptr_r];
  assign o_core_stall = (state_r != IDLE);
  assign o_dbg_rvalid = dbg_rvalid_r;
  assign o_dbg_rdata  = dbg_rdata_r;

  // Service decision for the FIFO head: pop, debug write, or core-blocked write
  always_comb begin
    pop_s     = 1'b0;
    blocked_s = 1'b0;
    dbg_wr_s  = 1'b0;
    case (state_r)
      DBG_RD: begin
        pop_s = !empty_s;
      end
      DBG_WR_FORCE: begin
        pop_s    = !empty_s;
        dbg_wr_s = !empty_s;
      end
      IDLE: begin
        if (!empty_s && head_we_s) begin
          if (i_core_wren) begin
            blocked_s = 1'b1;
          end else begin
            pop_s    = 1'b1;
            dbg_wr_s = 1'b1;
          end
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        pop_s = 1'b0;
      end
    endcase
  end

  // Look ahead to the head entry after this edge so a fresh read enters DBG_RD directly
  always_comb begin
    count_nxt_s   = count_r + {1'b0, push_s} - {1'b0, pop_s};
    rd_ptr_nxt_s  = rd_ptr_r ^ pop_s;
    nxt_head_rd_s = 1'b0;
    if (count_nxt_s == 2'd0) begin
      nxt_head_rd_s = 1'b0;
    end else if ((count_r - {1'b0, pop_s}) == 2'd0) begin
      nxt_head_rd_s = !i_dbg_we;
    end else begin
      nxt_head_rd_s = !fifo_we_r[rd_ptr_nxt_s];
    end
  end

  // Next-state and starvation counter
  always_comb begin
    state_nxt_s      = IDLE;
    starve_cnt_nxt_s = starve_cnt_r;
    case (state_r)
      IDLE: begin
        if (blocked_s) begin
          starve_cnt_nxt_s = starve_cnt_r + 4'd1;
          if (starve_cnt_nxt_s == FORCE_CNT) begin
            state_nxt_s = DBG_WR_FORCE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          if (dbg_wr_s) begin
            starve_cnt_nxt_s = 4'd0;
          end else begin
            starve_cnt_nxt_s = starve_cnt_r;
          end
          if (nxt_head_rd_s) begin
            state_nxt_s = DBG_RD;
          end else begin
            state_nxt_s = IDLE;
          end
        end
      end
      DBG_RD: begin
        state_nxt_s = IDLE;
      end
      DBG_WR_FORCE: begin
        state_nxt_s      = IDLE;
        starve_cnt_nxt_s = 4'd0;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Register-file port muxing; address 0 writes are swallowed
  always_comb begin
    o_rf_rs1_addr = i_core_rs1_addr;
    o_rf_rs2_addr = i_core_rs2_addr;
    o_rf_rd_wren  = i_core_wren;
    o_rf_rd_addr  = i_core_rd_addr;
    o_rf_rd_data  = i_core_rd_data;
    if (state_r == DBG_RD) begin
      o_rf_rs2_addr = head_addr_s;
      o_rf_rd_wren  = 1'b0;
    end else if (dbg_wr_s) begin
      o_rf_rd_wren  = (head_addr_s != 5'd0);
      o_rf_rd_addr  = head_addr_s;
      o_rf_rd_data  = head_data_s;
    end else begin
      o_rf_rd_wren  = i_core_wren;
    end
  end

  // Request FIFO storage and pointers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_we_r[i]   <= 1'b0;
        fifo_addr_r[i] <= 5'd0;
        fifo_data_r[i] <= 32'd0;
      end
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_we_r[wr_ptr_r]   <= i_dbg_we;
        fifo_addr_r[wr_ptr_r] <= i_dbg_addr;
        fifo_data_r[wr_ptr_r] <= i_dbg_wdata;
        wr_ptr_r              <= !wr_ptr_r;
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // FSM state and starvation counter registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Debug read return: strobe after each DBG_RD cycle, data held until the next read
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dbg_rvalid_r <= 1'b0;
      dbg_rdata_r  <= 32'd0;
    end else begin
      dbg_rvalid_r <= (state_r == DBG_RD);
      if (state_r == DBG_RD) begin
        dbg_rdata_r <= i_rf_rs2_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_arb.sv
// Bench for regfile_port_arb: directed scenarios plus random traffic checked
// against a queue-based model of the arbitration rules.
module tb_regfile_port_arb;
  localparam int LIMIT = 8;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [4:0]  i_core_rs1_addr, i_core_rs2_addr, i_core_rd_addr;
  logic        i_core_wren;
  logic [31:0] i_core_rd_data;
  logic        o_core_stall;
  logic        i_dbg_valid, i_dbg_we;
  logic [4:0]  i_dbg_addr;
  logic [31:0] i_dbg_wdata;
  logic        o_dbg_ready, o_dbg_rvalid;
  logic [31:0] o_dbg_rdata;
  logic [4:0]  o_rf_rs1_addr, o_rf_rs2_addr, o_rf_rd_addr;
  logic [31:0] i_rf_rs2_data, o_rf_rd_data;
  logic        o_rf_rd_wren;

  regfile_port_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_core_rs1_addr(i_core_rs1_addr), .i_core_rs2_addr(i_core_rs2_addr),
    .i_core_wren(i_core_wren), .i_core_rd_addr(i_core_rd_addr),
    .i_core_rd_data(i_core_rd_data), .o_core_stall(o_core_stall),
    .i_dbg_valid(i_dbg_valid), .i_dbg_we(i_dbg_we), .i_dbg_addr(i_dbg_addr),
    .i_dbg_wdata(i_dbg_wdata), .o_dbg_ready(o_dbg_ready),
    .o_dbg_rvalid(o_dbg_rvalid), .o_dbg_rdata(o_dbg_rdata),
    .o_rf_rs1_addr(o_rf_rs1_addr), .o_rf_rs2_addr(o_rf_rs2_addr),
    .i_rf_rs2_data(i_rf_rs2_data), .o_rf_rd_wren(o_rf_rd_wren),
    .o_rf_rd_addr(o_rf_rd_addr), .o_rf_rd_data(o_rf_rd_data)
  );

  always #5 i_clk = ~i_clk;

  logic [31:0] rf_mem [32];
  assign i_rf_rs2_data = rf_mem[o_rf_rs2_addr];

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  // Model: pending requests, what this cycle is spent on, blocked-cycle count
  req_t        mq[$];
  int          m_mode;     // 0 normal, 1 debug read cycle, 2 forced debug write cycle
  int          m_blocked;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int          n_checks = 0;
  int          n_fail = 0;
  logic        last_accept;
  logic [31:0] got_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    i_core_rs1_addr = 5'd0; i_core_rs2_addr = 5'd0; i_core_rd_addr = 5'd0;
    i_core_wren = 1'b0; i_core_rd_data = 32'd0;
    i_dbg_valid = 1'b0; i_dbg_we = 1'b0; i_dbg_addr = 5'd0; i_dbg_wdata = 32'd0;
  endtask

  // One clock: check outputs at the negedge against the model, advance at the posedge
  task automatic step();
    req_t        fq[$];
    logic        e_wren, e_ready, e_stall, n_rvalid;
    logic [4:0]  e_rs1, e_rs2, e_rdaddr;
    logic [31:0] e_rddata, n_rdata;
    int          n_mode, n_blocked;
    @(negedge i_clk);
    last_accept = 1'b0;
    if (i_reset) begin
      check_val("rst_stall", o_core_stall, 32'd0);
      check_val("rst_ready", o_dbg_ready, 32'd0);
      check_val("rst_rvalid", o_dbg_rvalid, 32'd0);
      check_val("rst_rdata", o_dbg_rdata, 32'd0);
      mq.delete(); m_mode = 0; m_blocked = 0; m_rvalid = 1'b0; m_rdata = 32'd0;
      @(posedge i_clk); #1;
      return;
    end
    if (o_dbg_rvalid) got_q.push_back(o_dbg_rdata);
    fq = mq;
    e_ready = (mq.size() < 2);
    e_stall = (m_mode != 0);
    e_rs1 = i_core_rs1_addr; e_rs2 = i_core_rs2_addr;
    e_wren = i_core_wren; e_rdaddr = i_core_rd_addr; e_rddata = i_core_rd_data;
    n_mode = 0; n_blocked = m_blocked; n_rvalid = 1'b0; n_rdata = m_rdata;
    if (m_mode == 1) begin
      e_rs2 = fq[0].addr; e_wren = 1'b0;
      n_rdata = rf_mem[fq[0].addr]; n_rvalid = 1'b1;
      void'(fq.pop_front());
    end else if (m_mode == 2) begin
      e_wren = (fq[0].addr != 5'd0); e_rdaddr = fq[0].addr; e_rddata = fq[0].data;
      n_blocked = 0;
      void'(fq.pop_front());
    end else if (fq.size() > 0 && fq[0].we) begin
      if (!i_core_wren) begin
        e_wren = (fq[0].addr != 5'd0); e_rdaddr = fq[0].addr; e_rddata = fq[0].data;
        n_blocked = 0;
        void'(fq.pop_front());
      end else begin
        n_blocked = m_blocked + 1;
        if (n_blocked == LIMIT - 1) n_mode = 2;
      end
    end
    if (i_dbg_valid && e_ready) begin
      fq.push_back({i_dbg_we, i_dbg_addr, i_dbg_wdata});
      last_accept = 1'b1;
    end
    if (m_mode == 0 && n_mode == 0 && fq.size() > 0 && !fq[0].we) n_mode = 1;
    check_val("stall", o_core_stall, e_stall);
    check_val("ready", o_dbg_ready, e_ready);
    check_val("rs1", o_rf_rs1_addr, e_rs1);
    check_val("rs2", o_rf_rs2_addr, e_rs2);
    check_val("wren", o_rf_rd_wren, e_wren);
    if (e_wren) begin
      check_val("rd_addr", o_rf_rd_addr, e_rdaddr);
      check_val("rd_data", o_rf_rd_data, e_rddata);
    end
    check_val("rvalid", o_dbg_rvalid, m_rvalid);
    check_val("rdata", o_dbg_rdata, m_rdata);
    @(posedge i_clk);
    mq = fq; m_mode = n_mode; m_blocked = n_blocked; m_rvalid = n_rvalid; m_rdata = n_rdata;
    #1;
  endtask

  initial begin
    logic busy;
    int   k;
    logic saw_block;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[3] = 32'h1234_5678;
    drive_idle();
    i_reset = 1'b1;
    step(); step();
    i_reset = 1'b0;
    step();

    // Debug write with idle core lands the cycle after acceptance
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd5; i_dbg_wdata = 32'hDEAD_BEEF;
    step();
    i_dbg_valid = 1'b0;
    #1;
    check_val("wr_wren", o_rf_rd_wren, 32'd1);
    check_val("wr_addr", o_rf_rd_addr, 32'd5);
    check_val("wr_data", o_rf_rd_data, 32'hDEAD_BEEF);
    check_val("wr_stall", o_core_stall, 32'd0);
    step();

    // Starvation: 7 core writes, one forced debug write, then core resumes
    i_core_wren = 1'b1; i_core_rd_addr = 5'd7; i_core_rd_data = 32'h1111_1111;
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd9; i_dbg_wdata = 32'hCAFE_F00D;
    step();
    i_dbg_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (c == LIMIT) begin
        check_val("starve_stall", o_core_stall, 32'd1);
        check_val("starve_wren", o_rf_rd_wren, 32'd1);
        check_val("starve_addr", o_rf_rd_addr, 32'd9);
        check_val("starve_data", o_rf_rd_data, 32'hCAFE_F00D);
      end else begin
        check_val("core_stall", o_core_stall, 32'd0);
        check_val("core_addr", o_rf_rd_addr, 32'd7);
      end
      step();
    end
    i_core_wren = 1'b0;

    // Debug read of x3
    i_dbg_valid = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd3;
    step();
    i_dbg_valid = 1'b0;
    #1;
    check_val("rd_stall", o_core_stall, 32'd1);
    check_val("rd_rs2", o_rf_rs2_addr, 32'd3);
    step();
    #1;
    check_val("rd_rvalid", o_dbg_rvalid, 32'd1);
    check_val("rd_rdata", o_dbg_rdata, 32'h1234_5678);
    check_val("rd_nostall", o_core_stall, 32'd0);
    step();

    // Write to x0 is popped without a write; the following request proceeds
    i_dbg_valid = 1'b1; i_dbg_we = 1'b1; i_dbg_addr = 5'd0; i_dbg_wdata = 32'hAAAA_5555;
    step();
    i_dbg_addr = 5'd6; i_dbg_wdata = 32'h0000_600D;
    #1;
    check_val("x0_wren", o_rf_rd_wren, 32'd0);
    step();
    i_dbg_valid = 1'b0;
    #1;
    check_val("x0_next_wren", o_rf_rd_wren, 32'd1);
    check_val("x0_next_addr", o_rf_rd_addr, 32'd6);
    step();

    // Back-to-back reads with valid held: backpressure and in-order return
    got_q.delete();
    k = 0; saw_block = 1'b0;
    for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
      if (k < 4) begin
        i_dbg_valid = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'(10 + k);
        if (!o_dbg_ready) saw_block = 1'b1;
      end else begin
        i_dbg_valid = 1'b0;
      end
      step();
      if (last_accept) k++;
    end
    i_dbg_valid = 1'b0;
    check_val("b2b_block", saw_block, 32'd1);
    check_val("b2b_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check_val("b2b_order", (got_q.size() > i) ? got_q[i] : 32'd0, rf_mem[10 + i]);
    step();

    // Reset during a debug read
    i_dbg_valid = 1'b1; i_dbg_we = 1'b0; i_dbg_addr = 5'd4;
    step();
    i_dbg_valid = 1'b0;
    #1;
    check_val("rr_stall_pre", o_core_stall, 32'd1);
    i_reset = 1'b1;
    #1;
    check_val("rr_stall", o_core_stall, 32'd0);
    step();
    i_reset = 1'b0;
    step();
    #1;
    check_val("rr_rvalid", o_dbg_rvalid, 32'd0);
    check_val("rr_ready", o_dbg_ready, 32'd1);
    step();

    // Random traffic
    busy = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (n % 100 == 0) busy = 1'($urandom_range(1, 0));
      i_core_wren     = busy ? ($urandom_range(31, 0) != 0) : 1'($urandom_range(1, 0));
      i_core_rs1_addr = 5'($urandom);
      i_core_rs2_addr = 5'($urandom);
      i_core_rd_addr  = 5'($urandom);
      i_core_rd_data  = $urandom;
      i_dbg_valid     = ($urandom_range(2, 0) == 0);
      i_dbg_we        = 1'($urandom_range(1, 0));
      i_dbg_addr      = ($urandom_range(5, 0) == 0) ? 5'd0 : 5'($urandom);
      i_dbg_wdata     = $urandom;
      i_reset         = ($urandom_range(299, 0) == 0);
      step();
    end
    i_reset = 1'b0;
    drive_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_port_arb.md
REGFILE_PORT_ARB -- requirements
Module: regfile_port_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive core-blocked cycles after which a pending debug write is forced (legal range 2..15).
REQ-002 SHALL have port i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have core-side ports:
- i_core_rs1_addr  input  5  core read address 1
- i_core_rs2_addr  input  5  core read address 2
- i_core_wren  input  1  core writeback enable
- i_core_rd_addr  input  5  core write address
- i_core_rd_data  input  32  core write data
- o_core_stall  output  1  core holds all inputs and writeback is dropped this cycle
REQ-005 SHALL have debug-side ports:
- i_dbg_valid  input  1  debug request valid
- i_dbg_we  input  1  1 = write, 0 = read
- i_dbg_addr  input  5  debug register address
- i_dbg_wdata  input  32  debug write data
- o_dbg_ready  output  1  request accepted when valid & ready
- o_dbg_rvalid  output  1  one-cycle read-data strobe
- o_dbg_rdata  output  32  debug read data
REQ-006 SHALL have register-file-side ports:
- o_rf_rs1_addr  output  5  read address 1
- o_rf_rs2_addr  output  5  read address 2
- i_rf_rs2_data  input  32  combinational read data 2
- o_rf_rd_wren  output  1  write enable
- o_rf_rd_addr  output  5  write address
- o_rf_rd_data  output  32  write data

Function
REQ-007 SHALL buffer accepted debug requests (we, addr, wdata) in a 2-entry in-order FIFO.
REQ-008 SHALL drive o_dbg_ready = !full; a push and a pop in the same cycle are legal when 1 entry is held.
REQ-009 SHALL implement FSM states IDLE, DBG_RD and DBG_WR_FORCE, plus a 4-bit starvation counter starve_cnt.
REQ-010 SHALL assert o_core_stall only while the state is DBG_RD or DBG_WR_FORCE, so stall is decoded from registered state only.
REQ-011 SHALL, in IDLE, pass the core signals straight through: rs1/rs2 addresses, and o_rf_rd_wren = i_core_wren with core address and data.
REQ-012 SHALL, in IDLE with the FIFO head a write and i_core_wren = 0, perform the head write combinationally that cycle, pop the head, and clear starve_cnt.
REQ-013 SHALL, in IDLE with the FIFO head a write and i_core_wren = 1, let the core write, increment starve_cnt, and move to DBG_WR_FORCE when starve_cnt reaches STARVE_LIMIT-1.
REQ-014 SHALL, in DBG_WR_FORCE, write the head entry, ignore i_core_wren, pop the head, clear starve_cnt, and return to IDLE after 1 cycle.
REQ-015 SHALL, in IDLE with the FIFO head a read, move to DBG_RD on the next edge without popping.
REQ-016 SHALL, in DBG_RD:
- drive o_rf_rs2_addr = head addr, with o_rf_rs1_addr still the core address
- force o_rf_rd_wren = 0
- capture i_rf_rs2_data into o_dbg_rdata at the edge
- pop the head and return to IDLE
REQ-017 SHALL pulse o_dbg_rvalid for exactly the 1 cycle after each DBG_RD cycle; o_dbg_rdata holds its value until the next read completes.
REQ-018 SHALL pop a debug write to address 0 normally but drive o_rf_rd_wren = 0 for it.
REQ-019 SHALL service only the FIFO head per cycle; a request pushed this cycle is eligible from the next cycle.
REQ-020 SHALL give a debug read minimum latency of 2 cycles from acceptance to rvalid (DBG_RD cycle, then rvalid) and 3 cycles worst case when the entry ahead is a non-blocked write.

Reset
REQ-021 SHALL, while i_reset = 1, hold:
- state = IDLE, FIFO empty, starve_cnt = 0
- o_core_stall = 0, o_dbg_rvalid = 0, o_dbg_rdata = 0
- o_dbg_ready = 0
REQ-022 SHALL, on reset asserted mid-operation, discard any FIFO contents and any in-progress DBG_RD or DBG_WR_FORCE without issuing its write or rvalid.

Verification
REQ-023 SHALL cover: debug write addr 5 data 0xDEADBEEF with i_core_wren = 0 -> o_rf_rd_wren = 1, addr 5, data 0xDEADBEEF in the cycle after acceptance, and no stall.
REQ-024 SHALL cover: i_core_wren held at 1 with a debug write pending, STARVE_LIMIT = 8 -> core writes for 7 cycles, then 1 stall cycle in which the debug data is written, then core writes resume.
REQ-025 SHALL cover: debug read addr 3 with regfile x3 = 0x12345678 -> 1 stall cycle with o_rf_rs2_addr = 3, then o_dbg_rvalid = 1 with o_dbg_rdata = 0x12345678.
REQ-026 SHALL cover: 3 back-to-back debug requests with valid held high -> ready drops after 2 entries are held, the 3rd is accepted after the first pop, and the requests are serviced in order.
REQ-027 SHALL cover: debug write to addr 0 -> entry popped, o_rf_rd_wren = 0.
REQ-028 SHALL cover: i_reset asserted during DBG_RD -> stall deasserts immediately, no rvalid is produced, and the FIFO is empty.
